v_logic_unit: RTL and testbench
===============================

Name: v_logic_unit

Overview:
- Parametrised next-generation vector logical ALU lane for the vALU.
- Eight bitwise ops, per-element masking at selectable SEW, configurable pipeline depth, and ready/valid backpressure with flush.
- Sits beside the other vALU units; result and address are tagged and returned to the vector register writeback path.

Parameters:
- REQ_DATA_WIDTH, 64: operand width in bits; multiple of 64.
- RESP_DATA_WIDTH, 64: result width; must equal REQ_DATA_WIDTH.
- REQ_ADDR_WIDTH, 32: destination address tag width.
- OPSEL_WIDTH, 3: opcode width.
- PIPE_DEPTH, 6: input-to-output latency in cycles; legal range 1..16.
- MASK_WIDTH, REQ_DATA_WIDTH/8: one mask bit per element; sized for SEW=8.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit accepts a request this cycle.
- in_addr  input  REQ_ADDR_WIDTH  destination tag.
- in_vec0  input  REQ_DATA_WIDTH  operand a.
- in_vec1  input  REQ_DATA_WIDTH  operand b.
- in_vec_old  input  REQ_DATA_WIDTH  old destination value, used for masked-off elements.
- in_opSel  input  OPSEL_WIDTH  operation code; encoding under Behaviour.
- in_sew  input  2  element width: 00=8, 01=16, 10=32, 11=64.
- in_mask  input  MASK_WIDTH  element enables; bit i applies to element i.
- in_vm  input  1  1 = unmasked, so in_mask is ignored.
- in_flush  input  1  synchronous pipeline kill.
- out_ready  input  1  consumer accepts the result.
- out_vec  output  RESP_DATA_WIDTH  result.
- out_valid  output  1  result valid.
- out_addr  output  REQ_ADDR_WIDTH  result tag.

Behaviour:
- Reset (rst=0, asynchronous): all stage valids, data and addresses clear to 0; out_vec=0, out_valid=0, out_addr=0. in_ready is 1 immediately after release.
- Opcode encoding:
  - 000 result 0
  - 001 a&b
  - 010 a|b
  - 011 a^b
  - 100 a&~b
  - 101 a|~b
  - 110 ~(a&b)
  - 111 ~(a^b)
- Op and mask merge happen in stage 0. Stages 1..PIPE_DEPTH-1 are pure delay. out_* is the last stage register.
- Element count is N = REQ_DATA_WIDTH / SEW.
  - Element i, for i<N: takes the op result if in_vm=1 or in_mask[i]=1; otherwise takes in_vec_old bits for that element.
  - Mask bits at index >= N are ignored.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - Acceptance occurs when in_valid && adv.
  - On adv, every stage shifts one place and stage 0 loads the accepted request.
  - If no request is accepted, stage 0 loads a bubble (valid 0, data 0, addr 0).
  - When adv=0, all stages hold.
- Invalid stages always carry data=0 and addr=0. out_vec and out_addr are 0 whenever out_valid=0.
- Latency: exactly PIPE_DEPTH cycles from acceptance to out_valid with no stall. Each stall cycle adds one.
- Throughput: one result per cycle while out_ready=1.
- out_valid && !out_ready: out_vec and out_addr stay stable until the handshake completes.
- in_flush=1: on the next edge all stage valids, data and addrs go to 0, overriding any shift. A request presented that cycle is dropped; in_ready is still driven as adv.
- Flush has priority over stall. Flush concurrent with an output handshake: the handshake completes and the pipeline is emptied.
- Reset mid-operation: all in-flight results are lost; no out_valid pulse follows.
- in_opSel, in_sew, in_mask and in_vm are sampled only on acceptance.

Test Plan:
- Reset and latency: after rst release, PIPE_DEPTH=6, SEW=64, vm=1, op=011, a=0xFF00FF00FF00FF00, b=0x0F0F0F0F0F0F0F0F, addr=0x40, out_ready=1 -> out_valid exactly 6 cycles later with out_vec=0xF00FF00FF00FF00F and out_addr=0x40; all other cycles show out_vec=0, out_addr=0.
- Opcode sweep: a=0xAAAA_AAAA_AAAA_AAAA, b=0xCCCC_CCCC_CCCC_CCCC, ops 000..111 back-to-back -> eight consecutive results:
  - 000: 0
  - 001: 0x8888…
  - 010: 0xEEEE…
  - 011: 0x6666…
  - 100: 0x2222…
  - 101: 0xBBBB…
  - 110: 0x7777…
  - 111: 0x9999…
- Masking: SEW=16, vm=0, mask=0b0101, op=001, a=b=all-ones, vec_old=0x1234_5678_9ABC_DEF0 -> out_vec=0x1234_FFFF_9ABC_FFFF.
- Backpressure: 10 back-to-back requests with out_ready held 0 for 4 cycles mid-stream -> no result lost or duplicated, in order, out_vec stable during the stall, in_ready=0 while out_valid && !out_ready.
- Flush: 3 requests in flight, then in_flush=1 for one cycle with a 4th request presented -> no out_valid from any of the 4. A 5th request issued afterwards returns after PIPE_DEPTH cycles.
- Async reset mid-stream: rst asserted between clock edges with 4 results in flight -> out_valid, out_vec and out_addr are 0 immediately, with no later valid pulses.

Source files
------------

// File: rtl/v_logic_unit.sv
// rtl/v_logic_unit.sv - vector logical ALU lane with SEW masking, fixed-depth pipeline and flush
module v_logic_unit #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH  = 32,
  parameter int OPSEL_WIDTH     = 3,
  parameter int PIPE_DEPTH      = 6,
  parameter int MASK_WIDTH      = REQ_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
  input  logic [REQ_DATA_WIDTH-1:0]  in_vec0,
  input  logic [REQ_DATA_WIDTH-1:0]  in_vec1,
  input  logic [REQ_DATA_WIDTH-1:0]  in_vec_old,
  input  logic [OPSEL_WIDTH-1:0]     in_opSel,
  input  logic [1:0]                 in_sew,
  input  logic [MASK_WIDTH-1:0]      in_mask,
  input  logic                       in_vm,
  input  logic                       in_flush,
  input  logic                       out_ready,
  output logic [RESP_DATA_WIDTH-1:0] out_vec,
  output logic                       out_valid,
  output logic [REQ_ADDR_WIDTH-1:0]  out_addr
);

  // One mask bit per byte is enough: every legal SEW is a whole number of bytes.
  localparam int NBYTES = REQ_DATA_WIDTH / 8;

  logic [REQ_DATA_WIDTH-1:0] r_data  [PIPE_DEPTH];
  logic [REQ_ADDR_WIDTH-1:0] r_addr  [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0]     r_valid;

  logic                      w_adv;
  logic                      w_accept;
  logic [2:0]                w_op;
  logic [REQ_DATA_WIDTH-1:0] w_op_res;
  logic [NBYTES-1:0]         w_byte_en;
  logic [REQ_DATA_WIDTH-1:0] w_merged;

  // The whole pipe moves together; a stalled output head freezes every stage.
  assign w_adv    = !r_valid[PIPE_DEPTH-1] || out_ready;
  assign w_accept = in_valid && w_adv;
  assign in_ready = w_adv;
  assign w_op     = in_opSel[2:0];

  // Bitwise operation selected by the opcode.
  always_comb begin
    w_op_res = '0;
    case (w_op)
      3'b000:  w_op_res = '0;
      3'b001:  w_op_res = in_vec0 & in_vec1;
      3'b010:  w_op_res = in_vec0 | in_vec1;
      3'b011:  w_op_res = in_vec0 ^ in_vec1;
      3'b100:  w_op_res = in_vec0 & ~in_vec1;
      3'b101:  w_op_res = in_vec0 | ~in_vec1;
      3'b110:  w_op_res = ~(in_vec0 & in_vec1);
      default: w_op_res = ~(in_vec0 ^ in_vec1);
    endcase
  end

  // Expand element mask bits to byte enables; element of byte b is b / (SEW/8),
  // so mask bits beyond the element count are never referenced.
  always_comb begin
    w_byte_en = '0;
    for (int b = 0; b < NBYTES; b++) begin
      case (in_sew)
        2'b00:   w_byte_en[b] = in_mask[b];
        2'b01:   w_byte_en[b] = in_mask[b/2];
        2'b10:   w_byte_en[b] = in_mask[b/4];
        default: w_byte_en[b] = in_mask[b/8];
      endcase
      if (in_vm) begin
        w_byte_en[b] = 1'b1;
      end
    end
  end

  // Merge op result with the old destination on masked-off bytes.
  always_comb begin
    w_merged = '0;
    for (int b = 0; b < NBYTES; b++) begin
      w_merged[b*8 +: 8] = w_byte_en[b] ? w_op_res[b*8 +: 8] : in_vec_old[b*8 +: 8];
    end
  end

  // Pipeline stages: flush beats stall; bubbles carry zero data and tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        r_data[s] <= '0;
        r_addr[s] <= '0;
      end
    end else if (in_flush) begin
      r_valid <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        r_data[s] <= '0;
        r_addr[s] <= '0;
      end
    end else if (w_adv) begin
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
        r_addr[s]  <= r_addr[s-1];
      end
      r_valid[0] <= w_accept;
      r_data[0]  <= w_accept ? w_merged : '0;
      r_addr[0]  <= w_accept ? in_addr : '0;
    end
  end

  assign out_valid = r_valid[PIPE_DEPTH-1];
  assign out_vec   = r_data[PIPE_DEPTH-1];
  assign out_addr  = r_addr[PIPE_DEPTH-1];

endmodule

// File: tb/tb_v_logic_unit.sv
// tb/tb_v_logic_unit.sv - directed self-checking bench for v_logic_unit
module tb_v_logic_unit;

  localparam int D = 6;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [63:0] in_vec0;
  logic [63:0] in_vec1;
  logic [63:0] in_vec_old;
  logic [2:0]  in_opSel;
  logic [1:0]  in_sew;
  logic [7:0]  in_mask;
  logic        in_vm;
  logic        in_flush;
  logic        out_ready;
  logic [63:0] out_vec;
  logic        out_valid;
  logic [31:0] out_addr;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  logic [95:0] exp_q[$];
  logic        held = 1'b0;
  logic [63:0] held_vec = '0;

  v_logic_unit #(
    .REQ_DATA_WIDTH(64), .RESP_DATA_WIDTH(64), .REQ_ADDR_WIDTH(32),
    .OPSEL_WIDTH(3), .PIPE_DEPTH(D), .MASK_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_vec0(in_vec0), .in_vec1(in_vec1),
    .in_vec_old(in_vec_old), .in_opSel(in_opSel), .in_sew(in_sew),
    .in_mask(in_mask), .in_vm(in_vm), .in_flush(in_flush),
    .out_ready(out_ready), .out_vec(out_vec), .out_valid(out_valid),
    .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] old, input logic [2:0] op, input logic [1:0] sew,
                           input logic [7:0] mask, input logic vm);
    in_valid   = 1'b1;
    in_addr    = addr;
    in_vec0    = a;
    in_vec1    = b;
    in_vec_old = old;
    in_opSel   = op;
    in_sew     = sew;
    in_mask    = mask;
    in_vm      = vm;
  endtask

  // Request must already be driven; expects out_valid exactly D edges later.
  task automatic latency_probe(input string tag, input logic [63:0] exp_vec, input logic [31:0] exp_addr);
    for (int k = 1; k <= D + 2; k++) begin
      tick();
      in_valid = 1'b0;
      check_eq({tag, "_valid"}, {63'd0, out_valid}, {63'd0, k == D});
      if (k == D) begin
        check_eq({tag, "_vec"}, out_vec, exp_vec);
        check_eq({tag, "_addr"}, {32'd0, out_addr}, {32'd0, exp_addr});
      end
    end
  endtask

  // Output monitor: scoreboard on handshakes, zero-when-idle, stability under stall.
  always @(negedge clk) begin
    if (!out_valid) begin
      check_eq("idle_vec", out_vec, 64'd0);
      check_eq("idle_addr", {32'd0, out_addr}, 64'd0);
    end else if (out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 64'd1, 64'd0);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        rx_cnt++;
        check_eq("out_vec", out_vec, e[63:0]);
        check_eq("out_addr", {32'd0, out_addr}, {32'd0, e[95:64]});
      end
    end
    if (out_valid && !out_ready) begin
      check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (held) check_eq("stall_stable", out_vec, held_vec);
      held     <= 1'b1;
      held_vec <= out_vec;
    end else begin
      held <= 1'b0;
    end
  end

  initial begin
    logic [63:0] sweep_exp [8];
    int sent;
    logic acc;
    sweep_exp[0] = 64'h0;
    sweep_exp[1] = 64'h8888_8888_8888_8888;
    sweep_exp[2] = 64'hEEEE_EEEE_EEEE_EEEE;
    sweep_exp[3] = 64'h6666_6666_6666_6666;
    sweep_exp[4] = 64'h2222_2222_2222_2222;
    sweep_exp[5] = 64'hBBBB_BBBB_BBBB_BBBB;
    sweep_exp[6] = 64'h7777_7777_7777_7777;
    sweep_exp[7] = 64'h9999_9999_9999_9999;

    rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_vec0 = '0; in_vec1 = '0;
    in_vec_old = '0; in_opSel = '0; in_sew = 2'b11; in_mask = '0; in_vm = 1'b1;
    in_flush = 1'b0; out_ready = 1'b1;

    // Reset state and single-request latency
    repeat (3) tick();
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_vec", out_vec, 64'd0);
    check_eq("rst_addr", {32'd0, out_addr}, 64'd0);
    rst = 1'b1;
    #1;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    drive_req(32'h40, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 64'd0, 3'b011, 2'b11, 8'h00, 1'b1);
    exp_q.push_back({32'h40, 64'hF00F_F00F_F00F_F00F});
    latency_probe("lat", 64'hF00F_F00F_F00F_F00F, 32'h40);

    // Opcode sweep, back to back
    for (int op = 0; op < 8; op++) begin
      drive_req(32'(op), 64'hAAAA_AAAA_AAAA_AAAA, 64'hCCCC_CCCC_CCCC_CCCC, 64'd0, 3'(op), 2'b11, 8'h00, 1'b1);
      exp_q.push_back({32'(op), sweep_exp[op]});
      tick();
    end
    in_valid = 1'b0;
    repeat (D + 3) tick();
    check_eq("sweep_drain", 64'(exp_q.size()), 64'd0);

    // Masking at various SEW, including ignored high mask bits
    drive_req(32'h50, ONES, ONES, 64'h1234_5678_9ABC_DEF0, 3'b001, 2'b01, 8'b0000_0101, 1'b0);
    exp_q.push_back({32'h50, 64'h1234_FFFF_9ABC_FFFF});
    tick();
    drive_req(32'h51, 64'd0, ONES, 64'h1234_5678_9ABC_DEF0, 3'b010, 2'b00, 8'h0F, 1'b0);
    exp_q.push_back({32'h51, 64'h1234_5678_FFFF_FFFF});
    tick();
    drive_req(32'h52, ONES, ONES, 64'h1234_5678_9ABC_DEF0, 3'b000, 2'b10, 8'hF2, 1'b0);
    exp_q.push_back({32'h52, 64'h0000_0000_9ABC_DEF0});
    tick();
    drive_req(32'h53, 64'h5A5A_5A5A_5A5A_5A5A, 64'h5A5A_5A5A_5A5A_5A5A, 64'h1234_5678_9ABC_DEF0, 3'b111, 2'b11, 8'h00, 1'b1);
    exp_q.push_back({32'h53, ONES});
    tick();
    in_valid = 1'b0;
    repeat (D + 3) tick();
    check_eq("mask_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: 10 requests with a 4-cycle output stall
    sent = 0;
    rx_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 7 && cyc < 11);
      if (sent < 10)
        drive_req(32'h100 + 32'(sent), 64'h0123_4567_89AB_CDEF + 64'(sent), ONES, 64'd0, 3'b011, 2'b11, 8'h00, 1'b1);
      else
        in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back({32'h100 + 32'(sent), ~(64'h0123_4567_89AB_CDEF + 64'(sent))});
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_sent", 64'(sent), 64'd10);
    check_eq("bp_received", 64'(rx_cnt), 64'd10);
    check_eq("bp_drain", 64'(exp_q.size()), 64'd0);

    // Flush with three in flight and a fourth presented alongside the flush
    for (int i = 0; i < 3; i++) begin
      drive_req(32'h200 + 32'(i), ONES, ONES, 64'd0, 3'b001, 2'b11, 8'h00, 1'b1);
      tick();
    end
    drive_req(32'h203, ONES, ONES, 64'd0, 3'b001, 2'b11, 8'h00, 1'b1);
    in_flush = 1'b1;
    #1;
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_flush = 1'b0;
    in_valid = 1'b0;
    repeat (D + 4) tick();
    drive_req(32'h205, 64'h0000_FFFF_0000_FFFF, 64'h00FF_00FF_00FF_00FF, 64'd0, 3'b010, 2'b11, 8'h00, 1'b1);
    exp_q.push_back({32'h205, 64'h00FF_FFFF_00FF_FFFF});
    latency_probe("post_flush", 64'h00FF_FFFF_00FF_FFFF, 32'h205);

    // Asynchronous reset with results in flight and the head stalled
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(32'h300 + 32'(i), ONES, ONES, 64'd0, 3'b001, 2'b11, 8'h00, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    check_eq("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("areset_valid", {63'd0, out_valid}, 64'd0);
    check_eq("areset_vec", out_vec, 64'd0);
    check_eq("areset_addr", {32'd0, out_addr}, 64'd0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (D + 6) tick();
    check_eq("final_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
